// File: rtl/switch_port_tx_if.sv
// Port-side bundle for switch_port_tx: pointer/data FIFO reads, pause, byte-wide TX, counters.
// Latency: none, wires only.
// Backpressure: tx_pause is the only throttle; FIFO reads are issued by the master side.
interface switch_port_tx_if;
  logic        ptr_fifo_empty;
  logic        ptr_fifo_rd;
  logic [15:0] ptr_fifo_dout;
  logic        data_fifo_rd;
  logic [7:0]  data_fifo_dout;
  logic        tx_pause;
  logic        tx_dv;
  logic        tx_sof;
  logic [7:0]  txd;
  logic [15:0] frame_cnt;
  logic [15:0] drop_cnt;

  // Transmit stage side
  modport master (
    input  ptr_fifo_empty, ptr_fifo_dout, data_fifo_dout, tx_pause,
    output ptr_fifo_rd, data_fifo_rd, tx_dv, tx_sof, txd, frame_cnt, drop_cnt
  );

  // Output queue / MAC side
  modport slave (
    output ptr_fifo_empty, ptr_fifo_dout, data_fifo_dout, tx_pause,
    input  ptr_fifo_rd, data_fifo_rd, tx_dv, tx_sof, txd, frame_cnt, drop_cnt
  );
endinterface

// File: rtl/switch_port_tx.sv
// Per-port TX: pops one descriptor, reads its bytes, sends preamble/SFD + frame, enforces IFG.
// Latency: descriptor pop to first preamble byte is 3 cycles; data byte leaves 2 cycles after its FIFO read.
// Backpressure: none downstream; tx_pause only blocks new frame starts (sampled in IDLE).
module switch_port_tx #(
  parameter int IFG_CYCLES = 12,
  parameter int MAX_LEN    = 1518,
  parameter int LEN_W      = 12
) (
  input logic            clk,
  input logic            rst,
  switch_port_tx_if.master port
);

  // IDLE->PTR_RD->PTR_LAT->PREAMBLE already spends 3 idle cycles, so IFG only holds the rest.
  localparam int IFG_HOLD = (IFG_CYCLES > 4) ? IFG_CYCLES - 4 : 0;
  localparam int CNT_W    = $clog2(IFG_CYCLES + 9);
  // First data read is issued while preamble byte 6 is on the wire: read -> dout -> txd register.
  localparam int RD_LEAD  = 5;

  typedef enum logic [2:0] {
    IDLE, PTR_RD, PTR_LAT, PREAMBLE, DATA, DRAIN, IFG
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [LEN_W-1:0] rd_left;
  logic [LEN_W-1:0] byte_left;
  logic [LEN_W-1:0] dlen;

  assign dlen = port.ptr_fifo_dout[LEN_W-1:0];

  // Upper descriptor bits carry no meaning for this stage.
  generate
    if (LEN_W < 16) begin : g_hi
      logic unused_hi;
      assign unused_hi = ^port.ptr_fifo_dout[15:LEN_W];
    end
  endgenerate

  // Frame sequencer; every output is a register written here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= IDLE;
      cnt               <= CNT_W'(IFG_HOLD);
      rd_left           <= '0;
      byte_left         <= '0;
      port.ptr_fifo_rd  <= 1'b0;
      port.data_fifo_rd <= 1'b0;
      port.tx_dv        <= 1'b0;
      port.tx_sof       <= 1'b0;
      port.txd          <= 8'h00;
      port.frame_cnt    <= 16'h0000;
      port.drop_cnt     <= 16'h0000;
    end else begin
      port.ptr_fifo_rd  <= 1'b0;
      port.data_fifo_rd <= 1'b0;
      port.tx_sof       <= 1'b0;
      case (state)
        IDLE: begin
          if (!port.ptr_fifo_empty && !port.tx_pause) begin
            state            <= PTR_RD;
            port.ptr_fifo_rd <= 1'b1;
          end
        end
        PTR_RD: begin
          state <= PTR_LAT;
        end
        PTR_LAT: begin
          if (dlen == '0) begin
            port.drop_cnt <= port.drop_cnt + 16'd1;
            state         <= IDLE;
          end else if (dlen > LEN_W'(MAX_LEN)) begin
            port.data_fifo_rd <= 1'b1;
            rd_left           <= dlen - LEN_W'(1);
            state             <= DRAIN;
          end else begin
            rd_left    <= dlen;
            byte_left  <= dlen;
            cnt        <= '0;
            port.tx_dv <= 1'b1;
            port.txd   <= 8'h55;
            state      <= PREAMBLE;
          end
        end
        PREAMBLE: begin
          cnt <= cnt + CNT_W'(1);
          if (cnt >= CNT_W'(RD_LEAD) && rd_left != '0) begin
            port.data_fifo_rd <= 1'b1;
            rd_left           <= rd_left - LEN_W'(1);
          end
          if (cnt == CNT_W'(6)) begin
            port.txd <= 8'hD5;
          end else if (cnt == CNT_W'(7)) begin
            port.txd    <= port.data_fifo_dout;
            port.tx_sof <= 1'b1;
            byte_left   <= byte_left - LEN_W'(1);
            state       <= DATA;
          end
        end
        DATA: begin
          if (rd_left != '0) begin
            port.data_fifo_rd <= 1'b1;
            rd_left           <= rd_left - LEN_W'(1);
          end
          if (byte_left != '0) begin
            port.txd  <= port.data_fifo_dout;
            byte_left <= byte_left - LEN_W'(1);
          end else begin
            port.tx_dv     <= 1'b0;
            port.txd       <= 8'h00;
            port.frame_cnt <= port.frame_cnt + 16'd1;
            cnt            <= '0;
            state          <= IFG;
          end
        end
        DRAIN: begin
          if (rd_left != '0) begin
            port.data_fifo_rd <= 1'b1;
            rd_left           <= rd_left - LEN_W'(1);
          end else begin
            port.drop_cnt <= port.drop_cnt + 16'd1;
            state         <= IDLE;
          end
        end
        IFG: begin
          if (cnt >= CNT_W'(IFG_HOLD)) begin
            state <= IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
